// File: rtl/conv_frame_pack_if.sv
// ============================================================================
// Module   : conv_frame_pack_if
// Brief    : Beat-in / frame-out handshake bundle for conv_frame_pack.
//            Optional o_frame_bits member is present when PACK_STATUS_EN is
//            defined. Also provides the code-rate selector encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

interface conv_frame_pack_if #(
  parameter int FRAME_W = 276
);
  logic               i_en;
  logic               i_code_rate;
  logic [1:0]         i_bits;
  logic               i_valid;
  logic               i_last;
  logic               o_ready;
  logic [FRAME_W-1:0] o_frame;
  logic               o_frame_valid;
  logic               i_frame_ready;
  logic               o_eod;
`ifdef PACK_STATUS_EN
  logic [8:0]         o_frame_bits;
`endif

  // Packer side: consumes beats, produces frames.
  modport slave (
    input  i_en, i_code_rate, i_bits, i_valid, i_last, i_frame_ready,
    output o_ready, o_frame, o_frame_valid, o_eod
`ifdef PACK_STATUS_EN
    , output o_frame_bits
`endif
  );

  // Environment side: produces beats, consumes frames.
  modport master (
    output i_en, i_code_rate, i_bits, i_valid, i_last, i_frame_ready,
    input  o_ready, o_frame, o_frame_valid, o_eod
`ifdef PACK_STATUS_EN
    , input o_frame_bits
`endif
  );
endinterface

`default_nettype wire

// File: rtl/conv_frame_pack.sv
// ============================================================================
// Module   : conv_frame_pack
// Brief    : K=3 convolutional encoder (rate 1/2 or 1/3, two info bits per
//            beat) packing coded symbols MSB-first into a FRAME_W-bit frame
//            with valid/ready frame handshake and end-of-data flag.
//            Optional macro PACK_STATUS_EN adds o_frame_bits (coded bits
//            written into the current frame, tail included).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_frame_pack #(
  parameter int         FRAME_W = 276,
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101,
  parameter logic [2:0] G2      = 3'b111
) (
  input  wire logic           clk,
  input  wire logic           rst,   // asynchronous, active low
  conv_frame_pack_if.slave    bus
);

  localparam int                   c_PTR_W = $clog2(FRAME_W);
  localparam logic [c_PTR_W-1:0]   c_TOP   = c_PTR_W'(FRAME_W - 1);
  localparam logic [c_PTR_W-1:0]   c_STEP2 = c_PTR_W'(4);
  localparam logic [c_PTR_W-1:0]   c_STEP3 = c_PTR_W'(6);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_TAIL = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t               r_state;
  logic [FRAME_W-1:0]   r_frame;
  logic                 r_valid;
  logic                 r_eod;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [1:0]           r_enc;        // {s1, s0}: previous two input bits
  logic                 r_rate;
  logic                 r_tail_pend;  // i_last beat filled a frame exactly

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_write;
  logic                 w_hs;
  logic                 w_rate;
  logic [1:0]           w_b;
  logic [2:0]           w_r0;
  logic [2:0]           w_r1;
  logic [3:0]           w_sym4;
  logic [5:0]           w_sym6;
  logic [c_PTR_W-1:0]   w_step;
  logic                 w_full;

  assign w_ready  = (r_state == S_FILL) && bus.i_en;
  assign w_accept = bus.i_valid && w_ready;
  // A beat is written either from the input or, in TAIL, as the flush beat.
  assign w_write  = bus.i_en && (w_accept || (r_state == S_TAIL));
  assign w_hs     = bus.i_en && (r_state == S_HOLD) && bus.i_frame_ready;

  // Rate follows the input only on the first beat of a frame.
  assign w_rate   = ((r_state == S_FILL) && (r_ptr == c_TOP)) ? bus.i_code_rate : r_rate;
  assign w_b      = (r_state == S_TAIL) ? 2'b00 : bus.i_bits;

  // u0 sees the stored state; u1 sees the state already advanced by u0.
  assign w_r0     = {w_b[0], r_enc};
  assign w_r1     = {w_b[1], w_b[0], r_enc[1]};
  assign w_sym4   = {^(w_r0 & G0), ^(w_r0 & G1), ^(w_r1 & G0), ^(w_r1 & G1)};
  assign w_sym6   = {^(w_r0 & G0), ^(w_r0 & G1), ^(w_r0 & G2),
                     ^(w_r1 & G0), ^(w_r1 & G1), ^(w_r1 & G2)};
  assign w_step   = (w_rate == `CODE_RATE_3) ? c_STEP3 : c_STEP2;
  // Frame is full when this write consumes the last remaining bits.
  assign w_full   = (r_ptr == (w_step - c_PTR_W'(1)));

  // Frame FSM, symbol placement and encoder state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_valid     <= 1'b0;
      r_eod       <= 1'b0;
      r_ptr       <= c_TOP;
      r_enc       <= 2'b00;
      r_rate      <= `CODE_RATE_2;
      r_tail_pend <= 1'b0;
    end else if (bus.i_en) begin
      if (w_write) begin
        if (w_rate == `CODE_RATE_3) begin
          r_frame[r_ptr -: 6] <= w_sym6;
        end else begin
          r_frame[r_ptr -: 4] <= w_sym4;
        end
        r_enc <= w_b;
        r_ptr <= r_ptr - w_step;
      end
      case (r_state)
        S_IDLE: r_state <= S_FILL;
        S_FILL: begin
          if (w_accept) begin
            r_rate <= w_rate;
            if (w_full) begin
              // An exactly-filling last beat defers its tail to a new frame.
              r_valid     <= 1'b1;
              r_state     <= S_HOLD;
              r_tail_pend <= bus.i_last;
            end else if (bus.i_last) begin
              r_state <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          r_valid <= 1'b1;
          r_eod   <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (w_hs) begin
            r_valid     <= 1'b0;
            r_frame     <= '0;
            r_ptr       <= c_TOP;
            r_eod       <= 1'b0;
            r_tail_pend <= 1'b0;
            if (r_eod) begin
              r_enc <= 2'b00;
            end
            r_state <= r_tail_pend ? S_TAIL : S_FILL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready       = w_ready;
  assign bus.o_frame       = r_frame;
  assign bus.o_frame_valid = r_valid;
  assign bus.o_eod         = r_eod;

`ifdef PACK_STATUS_EN
  logic [8:0] r_bits;
  logic [8:0] w_step_bits;

  assign w_step_bits = (w_rate == `CODE_RATE_3) ? 9'd6 : 9'd4;

  // Coded-bit count of the frame under construction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bits <= 9'd0;
    end else if (w_hs) begin
      r_bits <= 9'd0;
    end else if (w_write) begin
      r_bits <= r_bits + w_step_bits;
    end
  end

  assign bus.o_frame_bits = r_bits;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_pack.sv
// ============================================================================
// Module   : tb_conv_frame_pack
// Brief    : Self-checking bench for conv_frame_pack with a bit-queue
//            reference model of the convolutional encoder and frame packing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_conv_frame_pack;
  localparam int         FW  = 276;
  localparam logic [2:0] TG0 = 3'b111;
  localparam logic [2:0] TG1 = 3'b101;
  localparam logic [2:0] TG2 = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_frame_pack_if #(.FRAME_W(FW)) bus();

  conv_frame_pack #(.FRAME_W(FW), .G0(TG0), .G1(TG1), .G2(TG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the coded stream as a queue of bits, frame = queue MSB-first.
  bit m_p1, m_p2;   // last and second-to-last info bits of the stream
  bit m_r3;         // rate used by the current model frame
  bit m_q[$];

  function automatic bit cbit(input logic [2:0] g, input bit u, input bit p1, input bit p2);
    return (g[2] & u) ^ (g[1] & p1) ^ (g[0] & p2);
  endfunction

  task automatic model_beat(input logic [1:0] b, input bit r3);
    bit u;
    if (m_q.size() == 0) m_r3 = r3;
    for (int k = 0; k < 2; k++) begin
      u = b[k];
      m_q.push_back(cbit(TG0, u, m_p1, m_p2));
      m_q.push_back(cbit(TG1, u, m_p1, m_p2));
      if (m_r3) m_q.push_back(cbit(TG2, u, m_p1, m_p2));
      m_p2 = m_p1;
      m_p1 = u;
    end
  endtask

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    f = '0;
    foreach (m_q[i]) f[FW-1-i] = m_q[i];
    return f;
  endfunction

  task automatic model_clear(input bit end_of_stream);
    m_q.delete();
    if (end_of_stream) begin
      m_p1 = 1'b0;
      m_p2 = 1'b0;
    end
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_frame_ready = 1'b0;
    bus.i_en = 1'b1; bus.i_bits = 2'b00; bus.i_code_rate = `CODE_RATE_2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    model_clear(1'b1);
  endtask

  task automatic send_beat(input logic [1:0] b, input bit last);
    int waited;
    waited = 0;
    bus.i_bits = b; bus.i_last = last; bus.i_valid = 1'b1;
    while (bus.o_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.o_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL beat_ready: o_ready=%b required 1 within 20 cycles", bus.o_ready);
    end else begin
      model_beat(b, bus.i_code_rate == `CODE_RATE_3);
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0; bus.i_last = 1'b0;
  endtask

  task automatic handshake(input bit was_eod);
    bus.i_frame_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_ready = 1'b0;
    model_clear(was_eod);
  endtask

  task automatic test_reset();
    logic [FW-1:0] fr;
    bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_frame_ready = 1'b0;
    bus.i_en = 1'b1; bus.i_bits = 2'b00; bus.i_code_rate = `CODE_RATE_2;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    fr = bus.o_frame;
    n_cmp++; if (fr !== '0) begin n_err++; $display("FAIL reset_frame: got %h required 0", fr); end
    n_cmp++; if (bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", bus.o_frame_valid); end
    n_cmp++; if (bus.o_eod !== 1'b0) begin n_err++; $display("FAIL reset_eod: got %b required 0", bus.o_eod); end
`ifdef PACK_STATUS_EN
    n_cmp++; if (bus.o_frame_bits !== 9'd0) begin n_err++; $display("FAIL reset_bits: got %0d required 0", bus.o_frame_bits); end
`endif
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b required 0", bus.o_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready: got %b required 1", bus.o_ready); end
    model_clear(1'b1);
  endtask

  task automatic test_rate2_first();
    logic [FW-1:0] fr;
    logic [3:0]    sl;
    do_reset();
    send_beat(2'b11, 1'b0);
    fr = bus.o_frame; sl = fr[275:272];
    n_cmp++; if (sl !== 4'b1101) begin n_err++; $display("FAIL r2_beat1: got %b required 1101", sl); end
    send_beat(2'b11, 1'b0);
    fr = bus.o_frame; sl = fr[271:268];
    n_cmp++; if (sl !== 4'b1010) begin n_err++; $display("FAIL r2_beat2: got %b required 1010", sl); end
    n_cmp++; if (fr !== model_frame()) begin n_err++; $display("FAIL r2_frame: got %h required %h", fr, model_frame()); end
  endtask

  task automatic test_rate3_first();
    logic [FW-1:0] fr;
    logic [5:0]    sl;
    do_reset();
    bus.i_code_rate = `CODE_RATE_3;
    send_beat(2'b11, 1'b0);
    fr = bus.o_frame; sl = fr[275:270];
    n_cmp++; if (sl !== 6'b111010) begin n_err++; $display("FAIL r3_beat1: got %b required 111010", sl); end
    send_beat(2'($urandom()), 1'b0);
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL r3_frame: got %h required %h", bus.o_frame, model_frame()); end
  endtask

  task automatic test_full_frame();
    logic [FW-1:0] snap;
    do_reset();
    for (int i = 1; i <= 68; i++) send_beat(2'($urandom()), 1'b0);
    n_cmp++; if (bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL full_early: valid=%b required 0 after 68 beats", bus.o_frame_valid); end
    send_beat(2'($urandom()), 1'b0);
    n_cmp++; if (bus.o_frame_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b required 1", bus.o_frame_valid); end
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b required 0", bus.o_ready); end
    n_cmp++; if (bus.o_eod !== 1'b0) begin n_err++; $display("FAIL full_eod: got %b required 0", bus.o_eod); end
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL full_frame: got %h required %h", bus.o_frame, model_frame()); end
`ifdef PACK_STATUS_EN
    n_cmp++; if (bus.o_frame_bits !== 9'd276) begin n_err++; $display("FAIL full_bits: got %0d required 276", bus.o_frame_bits); end
`endif
    snap = model_frame();
    // Disabled block ignores i_frame_ready.
    bus.i_en = 1'b0; bus.i_frame_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bus.o_frame_valid !== 1'b1) begin n_err++; $display("FAIL en_freeze: valid=%b required 1", bus.o_frame_valid); end
    bus.i_frame_ready = 1'b0; bus.i_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.o_frame !== snap || bus.o_frame_valid !== 1'b1) begin
        n_err++; $display("FAIL hold_stable: cycle %0d valid=%b frame=%h required %h", i, bus.o_frame_valid, bus.o_frame, snap);
      end
    end
    handshake(1'b0);
    n_cmp++; if (bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL hs_valid: got %b required 0", bus.o_frame_valid); end
    n_cmp++; if (bus.o_frame !== '0) begin n_err++; $display("FAIL hs_clear: got %h required 0", bus.o_frame); end
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready: got %b required 1", bus.o_ready); end
  endtask

  // Second frame straight after the first: encoder memory must carry over.
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) send_beat(2'($urandom()), 1'b0);
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL b2b_frame: got %h required %h", bus.o_frame, model_frame()); end
  endtask

  task automatic test_last_tail();
    do_reset();
    for (int i = 1; i <= 10; i++) send_beat(2'($urandom()), (i == 10));
    n_cmp++; if (bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL tail_early: valid=%b required 0", bus.o_frame_valid); end
    model_beat(2'b00, m_r3);
    @(posedge clk); #1;
    n_cmp++; if (bus.o_frame_valid !== 1'b1) begin n_err++; $display("FAIL tail_valid: got %b required 1", bus.o_frame_valid); end
    n_cmp++; if (bus.o_eod !== 1'b1) begin n_err++; $display("FAIL tail_eod: got %b required 1", bus.o_eod); end
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL tail_frame: got %h required %h", bus.o_frame, model_frame()); end
`ifdef PACK_STATUS_EN
    n_cmp++; if (bus.o_frame_bits !== 9'd44) begin n_err++; $display("FAIL tail_bits: got %0d required 44", bus.o_frame_bits); end
`endif
    handshake(1'b1);
    n_cmp++; if (bus.o_eod !== 1'b0 || bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL tail_hs: eod=%b valid=%b required 0 0", bus.o_eod, bus.o_frame_valid); end
    send_beat(2'($urandom()), 1'b0);
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL post_eod_frame: got %h required %h", bus.o_frame, model_frame()); end
  endtask

  task automatic test_rate_change();
    do_reset();
    for (int i = 1; i <= 69; i++) begin
      if (i == 5) bus.i_code_rate = `CODE_RATE_3;
      send_beat(2'($urandom()), 1'b0);
      if (i == 46) begin
        n_cmp++; if (bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL rc_46: valid=%b required 0", bus.o_frame_valid); end
      end
    end
    n_cmp++; if (bus.o_frame_valid !== 1'b1) begin n_err++; $display("FAIL rc_valid: got %b required 1", bus.o_frame_valid); end
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL rc_frame: got %h required %h", bus.o_frame, model_frame()); end
    bus.i_code_rate = `CODE_RATE_2;
    handshake(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] fr;
    logic [3:0]    sl;
    do_reset();
    for (int i = 0; i < 30; i++) send_beat(2'($urandom()), 1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.o_frame !== '0) begin n_err++; $display("FAIL mid_rst_frame: got %h required 0", bus.o_frame); end
    n_cmp++; if (bus.o_frame_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b required 0", bus.o_frame_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    model_clear(1'b1);
    send_beat(2'b11, 1'b0);
    fr = bus.o_frame; sl = fr[275:272];
    n_cmp++; if (sl !== 4'b1101) begin n_err++; $display("FAIL mid_rst_restart: got %b required 1101", sl); end
    n_cmp++; if (fr !== model_frame()) begin n_err++; $display("FAIL mid_rst_frame2: got %h required %h", fr, model_frame()); end
  endtask

  task automatic test_tail_on_full();
    do_reset();
    bus.i_code_rate = `CODE_RATE_3;
    for (int i = 1; i <= 46; i++) send_beat(2'($urandom()), (i == 46));
    n_cmp++; if (bus.o_frame_valid !== 1'b1 || bus.o_eod !== 1'b0) begin n_err++; $display("FAIL tof_first: valid=%b eod=%b required 1 0", bus.o_frame_valid, bus.o_eod); end
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL tof_frame1: got %h required %h", bus.o_frame, model_frame()); end
    handshake(1'b0);
    model_beat(2'b00, 1'b1);
    n_cmp++; if (bus.o_frame_valid !== 1'b0 || bus.o_ready !== 1'b0) begin n_err++; $display("FAIL tof_gap: valid=%b ready=%b required 0 0", bus.o_frame_valid, bus.o_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_frame_valid !== 1'b1 || bus.o_eod !== 1'b1) begin n_err++; $display("FAIL tof_second: valid=%b eod=%b required 1 1", bus.o_frame_valid, bus.o_eod); end
    n_cmp++; if (bus.o_frame !== model_frame()) begin n_err++; $display("FAIL tof_frame2: got %h required %h", bus.o_frame, model_frame()); end
`ifdef PACK_STATUS_EN
    n_cmp++; if (bus.o_frame_bits !== 9'd6) begin n_err++; $display("FAIL tof_bits: got %0d required 6", bus.o_frame_bits); end
`endif
    handshake(1'b1);
  endtask

  initial begin
    test_reset();
    test_rate2_first();
    test_rate3_first();
    test_full_frame();
    test_back_to_back();
    test_last_tail();
    test_rate_change();
    test_reset_mid();
    test_tail_on_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/conv_frame_pack.md
Name: conv_frame_pack

Overview:
Transmit-side partner of the decoder's frame slicer. It convolutionally encodes two information bits per cycle (K=3, rate 1/2 or 1/3) and packs the coded symbols MSB-first into a FRAME_W-bit frame. The frame layout is exactly what the slicer walks from the top index downward. A frame is presented on a valid/ready handshake, and an end-of-data flag marks the final frame.

Parameters:
FRAME_W, 276, frame width in bits; must be divisible by 4 and 6.
G0, 3'b111, generator for coded bit c0 (bit2 = current input).
G1, 3'b101, generator for coded bit c1.
G2, 3'b111, generator for coded bit c2 (rate 1/3 only).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
i_en  in  1  block enable; 0 freezes all state, outputs hold
i_code_rate  in  1  `CODE_RATE_2 or `CODE_RATE_3; sampled at frame start
i_bits  in  2  information bits; i_bits[0] earlier in time than i_bits[1]
i_valid  in  1  i_bits valid
i_last  in  1  with i_valid: final beat of the data stream
o_ready  out  1  block accepts a beat this cycle
o_frame  out  FRAME_W  packed coded frame
o_frame_valid  out  1  o_frame complete and stable
i_frame_ready  in  1  consumer takes the frame
o_eod  out  1  with o_frame_valid: last frame of the stream

Behaviour:
- Reset (rst=0, async): state IDLE, o_frame=0, o_frame_valid=0, o_eod=0, ptr=FRAME_W-1, enc_state=2'b00, rate register=`CODE_RATE_2.
- FSM: IDLE -> FILL (unconditional, first enabled cycle). FILL -> TAIL (i_last accepted). FILL -> HOLD (frame full). TAIL -> HOLD. HOLD -> FILL (handshake).
- o_ready = (state==FILL) && i_en.
- Beat acceptance: accepted when i_valid && o_ready.
- Encoding per bit u: r = {u, s1, s0}, cj = ^(r & Gj); then {s1,s0} <= {u,s1}. u0 = i_bits[0] is encoded first, then u1 from the updated state, all in one cycle.
- Rate 1/2 placement: o_frame[ptr] = c0(u0), [ptr-1] = c1(u0), [ptr-2] = c0(u1), [ptr-3] = c1(u1); then ptr -= 4.
- Rate 1/3 placement: [ptr..ptr-2] = c0,c1,c2 of u0; [ptr-3..ptr-5] = c0,c1,c2 of u1; then ptr -= 6.
- Rate sampling: the rate is latched on the first accepted beat of each frame (ptr == FRAME_W-1). Any later change of i_code_rate within the frame is ignored.
- Frame full: when ptr would step below 0, state -> HOLD and o_frame_valid=1 on the next cycle. 69 beats at rate 1/2, 46 at rate 1/3.
- TAIL: one internal beat with i_bits=2'b00 is written (no o_ready), returning enc_state to 00. Remaining bits stay 0. Then HOLD with o_eod=1.
- Tail on a full frame: if the i_last beat fills the frame exactly, the frame is emitted with o_eod=0. After that handshake the tail beat is written at the top of the next frame, which is emitted with o_eod=1.
- HOLD: o_frame, o_frame_valid and o_eod stay stable until i_frame_ready=1.
- Handshake cycle: o_frame_valid drops the next cycle, o_frame clears to 0, ptr=FRAME_W-1.
- Stream end: enc_state is reset to 00 only after an o_eod frame. Otherwise it carries across frame boundaries.
- i_en=0: no acceptance and no state change, including in HOLD. i_frame_ready is ignored.
- Latency: bits are visible in o_frame one cycle after acceptance; o_frame_valid rises one cycle after the last write.
- Reset mid-frame: partial frame discarded and all reset values apply immediately; no frame is emitted.

Optional Feature:
Macro PACK_STATUS_EN.
- Defined: adds output o_frame_bits [8:0], the count of coded bits written in the current frame (tail included). It is registered, valid with o_frame_valid, and 0 on reset and after each handshake.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Rate 1/2, after reset, first beat i_bits=2'b11 -> o_frame[275:272] = 1,1,0,1. Next beat 2'b11 -> [271:268] = 1,0,1,0.
- Rate 1/3, first beat 2'b11 -> o_frame[275:270] = 1,1,1,0,1,0.
- Rate 1/2, 69 beats of random bits with i_frame_ready=0 -> o_frame_valid=1 one cycle after beat 69 and o_ready=0. o_frame is stable for 20 cycles; it clears after the i_frame_ready pulse and o_ready returns.
- Rate 1/2, 10 beats with i_last on beat 10 -> frame bits 275..232 written, bits 231..0 = 0, o_eod=1. With PACK_STATUS_EN, o_frame_bits=44.
- Rate 1/2 at frame start, i_code_rate toggled to `CODE_RATE_3 at beat 5 -> whole frame uses 4-bit placement; o_frame_valid after beat 69.
- Rate 1/2, rst pulled low after beat 30 -> o_frame=0 and o_frame_valid=0 immediately. Restart produces the same first symbols as after the initial reset.
